// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: operation/handshake and HI/LO bus between the core control unit and the mul/div unit.
interface mips_muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hilo_wr;
  logic            hilo_sel;
  logic [XLEN-1:0] hilo_data;
  logic            busy;
  logic            done;
  logic            dz;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master (output start, op, a, b, hilo_wr, hilo_sel, hilo_data, input busy, done, dz, hi, lo);
  modport slave (input start, op, a, b, hilo_wr, hilo_sel, hilo_data, output busy, done, dz, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module mips_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  mips_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_mp, r_hi, r_lo;
  logic [2*XLEN-1:0] r_acc, r_mc;
  logic [CW-1:0]     r_cnt;
  logic              r_done, r_dz;
  logic              w_div, w_sgn, w_na, w_nb, w_ge, w_last;
  logic [XLEN-1:0]   w_ma, w_mb, w_q, w_rem, w_diff;
  logic [XLEN:0]     w_rs;
  logic [2*XLEN-1:0] w_prod;
  assign w_div  = r_op[1];
  assign w_sgn  = ~r_op[0];
  assign w_na   = w_sgn & r_a[XLEN-1];
  assign w_nb   = w_sgn & r_b[XLEN-1];
  assign w_ma   = w_na ? -r_a : r_a;
  assign w_mb   = w_nb ? -r_b : r_b;
  // Divide step: remainder shifted left with the next dividend bit, then trial-subtracted
  assign w_rs   = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge   = w_rs >= {1'b0, r_mp};
  assign w_diff = w_rs[XLEN-1:0] - r_mp;
  assign w_q    = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[2*XLEN-1:XLEN];
  assign w_prod = (w_na ^ w_nb) ? -r_acc : r_acc;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == CW'(XLEN - 1)) || (!w_div && (r_mp >> 1) == '0);
`else
  assign w_last = r_cnt == CW'(XLEN - 1);
`endif
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? PREP : IDLE) :
             r_state == PREP ? ITER :
             r_state == ITER ? (w_last ? FIX : ITER) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == FIX;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
          end else if (bus.hilo_wr) begin
            if (bus.hilo_sel) r_hi <= bus.hilo_data;
            else r_lo <= bus.hilo_data;
          end
        end
        PREP: begin
          r_cnt <= '0;
          r_mp  <= w_mb;
          r_mc  <= {{XLEN{1'b0}}, w_ma};
          r_acc <= w_div ? {{XLEN{1'b0}}, w_ma} : '0;
        end
        ITER: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_div) begin
            r_acc <= {(w_ge ? w_diff : w_rs[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
          end else begin
            r_acc <= r_mp[0] ? r_acc + r_mc : r_acc;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
          end
        end
        FIX: begin
          if (!w_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_b == '0) begin
            r_hi <= r_a;
            r_lo <= '1;
            r_dz <= 1'b1;
          end else begin
            r_hi <= w_na ? -w_rem : w_rem;
            r_lo <= (w_na ^ w_nb) ? -w_q : w_q;
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  assign bus.dz   = r_dz;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed and random operations checked against a plain-arithmetic HI/LO model.
module tb_mips_muldiv_unit;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic m_dz = 1'b0;
  mips_muldiv_unit_if #(.XLEN(XLEN)) bus ();
  mips_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int cyc);
    longint sa, sb;
    logic [31:0] mb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = XLEN + 2;
    mb  = (!op[0] && b[31]) ? -b : b;
    if (!op[1]) begin
      {hi, lo} = op[0] ? {32'b0, a} * {32'b0, b} : 64'(sa * sb);
`ifdef MULDIV_EARLY_OUT_EN
      cyc = 3;
      for (int i = 1; i < 32; i++) if (mb[i]) cyc = i + 3;
`endif
    end else if (b == 0) begin
      hi   = a;
      lo   = '1;
      m_dz = 1'b1;
    end else begin
      m_dz = 1'b0;
      if (op[0]) begin
        lo = a / b;
        hi = a % b;
      end else begin
        lo = 32'(sa / sb);
        hi = 32'(sa % sb);
      end
    end
  endtask
  // Called at a negedge in an idle or done cycle; returns at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ehi, elo;
    int ecyc, cyc;
    ref_op(op, a, b, ehi, elo, ecyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(cyc), 64'(ecyc));
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
    chk({tag, " dz"}, 64'(bus.dz), 64'(m_dz));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int  cyc;
    bit  seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hilo_wr = 0; bus.hilo_sel = 0; bus.hilo_data = 0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dz", 64'(bus.dz), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, "mult_m3x7");
    @(negedge clk);
    chk("done pulse width", 64'(bus.done), 64'd0);
    chk("idle after done", 64'(bus.busy), 64'd0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    do_op(2'b00, 32'd5, 32'd3, "mult_5x3");
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    do_op(2'b11, 32'd7, 32'd2, "divu_7_2");
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    do_op(2'b11, 32'd5, 32'd0, "divu_dz");
    do_op(2'b01, 32'd3, 32'd3, "multu_keeps_dz");
    do_op(2'b10, 32'hFFFFFFF0, 32'd0, "div_dz_signed");
    do_op(2'b11, 32'd6, 32'd3, "divu_clr_dz");
    // start and hilo_wr while busy must both be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_data = 32'hABCD;
    @(negedge clk);
    bus.hilo_wr = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_ignore done", 64'(bus.done), 64'd1);
    chk("busy_ignore hi", 64'(bus.hi), 64'd0);
    chk("busy_ignore lo", 64'(bus.lo), 64'd6);
    @(negedge clk);
    chk("busy_ignore not queued", 64'(bus.busy), 64'd0);
    // reset in the middle of an operation
    do_op(2'b11, 32'd5, 32'd0, "divu_dz_pre_rst");
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_dz = 1'b0;
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst hi", 64'(bus.hi), 64'd0);
    chk("midrst lo", 64'(bus.lo), 64'd0);
    chk("midrst dz", 64'(bus.dz), 64'd0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
    end
    chk("midrst no done", 64'(seen), 64'd0);
    // idle HI/LO writes, then a start with hilo_wr in the same cycle
    bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_data = 32'h1234;
    @(negedge clk);
    bus.hilo_sel = 1'b0; bus.hilo_data = 32'h5678;
    @(negedge clk);
    bus.hilo_wr = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h1234);
    chk("mtlo", 64'(bus.lo), 64'h5678);
    bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_data = 32'hDEAD;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.hilo_wr = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    m_dz = 1'b1;
    chk("start_wins hi", 64'(bus.hi), 64'd9);
    chk("start_wins lo", 64'(bus.lo), 64'hFFFFFFFF);
    do_op(2'b01, 32'd4, 32'd4, "b2b_multu_4x4");
    do_op(2'b00, 32'd9, 32'hFFFFFFFF, "b2b_mult_9xm1");
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 1) rb = 32'($urandom_range(0, 15));
      if (i % 7 == 3) rb = 0;
      if (i % 6 == 2) rb = -rb;
      do_op(rop, ra, rb, "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
